iter_muldiv_unit: RTL
=====================

// Module: iter_muldiv_unit
// PURPOSE
//  Parametrised iterative RV M-extension execute unit: all 8 funct3 ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Sits beside the EX-stage ALU; hazard unit stalls on busy, flushes via kill. One result bit per cycle.
//  Successor to the fixed 32-bit multiplier/divider pair; adds XLEN generalisation, a unified handshake and kill.
// PARAMETERS
//  XLEN    32   operand/result width; legal values 8..64.
//  CNT_W   $clog2(XLEN)   iteration counter width; derived, do not override.
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  start      in   1     request; sampled only in IDLE
//  kill       in   1     abort in-flight op (pipeline flush)
//  op         in   3     RV funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  operand_a  in   XLEN  rs1 value (multiplicand / dividend)
//  operand_b  in   XLEN  rs2 value (multiplier / divisor)
//  busy       out  1     high in BUSY and DONE; stall request
//  done       out  1     one-cycle pulse, result valid
//  result     out  XLEN  final result; held until next accepted start
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  - FSM IDLE->BUSY->DONE->IDLE.
//    IDLE: start=1 at edge N latches op and operands; signed ops latch |operand|; records result sign; counter=0 -> BUSY.
//    BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//      Counter increments each cycle; at counter==XLEN-1 -> DONE.
//    DONE: done=1 exactly one cycle; result updated on entry; -> IDLE.
//  - Latency: start sampled at edge N -> done high in cycle following edge N+XLEN+1 (XLEN=32: 33 cycles).
//  - start while busy=1 is ignored, not queued. A start in IDLE is accepted even on the cycle after DONE.
//  - Multiply: 2*XLEN product register. MUL returns low half; MULH/MULHSU/MULHU return high half.
//    Signedness: MULH s*s, MULHSU s(a)*u(b), MULHU u*u. Negate the 2*XLEN product when signs differ.
//  - Divide: quotient and remainder from magnitudes.
//    Quotient negated iff signs of a and b differ. Remainder takes the sign of a.
//    DIV/REM are signed; DIVU/REMU are unsigned.
//  - Divide by zero (b==0): quotient=all ones, remainder=a, for every div op.
//    Sign fix-up is suppressed for the quotient.
//  - Signed overflow (a=most-negative, b=-1): DIV returns most-negative, REM returns 0.
//  - kill=1 in BUSY or DONE: next edge -> IDLE, busy=0. done does not assert (a kill in DONE masks the pulse).
//    result keeps its previous value. kill in IDLE has no effect.
//    kill and start together in IDLE: kill wins, start is dropped.
//  - Reset mid-operation: immediate return to reset values. No done.
//  - All arithmetic is modulo widths stated. No X propagation from unused operand bits.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//    Div-by-zero, signed overflow, and either mul operand ==0 go IDLE->DONE directly.
//    done fires the cycle after edge N (latency 1). Results are identical.
//  Undefined: every op takes the full XLEN+1 latency. No comparators on special cases.
// TESTING
//  T1 XLEN=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start edge.
//  T2 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
//  T3 DIV a=0xFFFFFFFB b=0 -> 0xFFFFFFFF; REM same operands -> 0xFFFFFFFB.
//     With MULDIV_EARLY_OUT_EN the same results arrive with latency 1.
//  T4 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0. DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
//  T5 start DIVU, kill at 10th BUSY cycle -> busy=0 next cycle, no done, result unchanged.
//     Second start pulse mid-BUSY ignored. A following DIVU 100/7 -> 14.
//  T6 rst low mid-MUL -> busy/done/result=0 asynchronously. Re-run at XLEN=16: MUL 0x00FF*0x0101 -> 0xFFFF, latency 17.

Source files
------------

// File: rtl/iter_muldiv_unit.sv
// Iterative RV M-extension execute unit: one multiply/divide result bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (b==0 div, signed overflow, zero mul operand) finish in one cycle.
module iter_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fin;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_mcand;
    logic             r_prod_neg;
    logic             r_rem_neg;
    logic             r_bzero;
    logic [XLEN-1:0]  r_stage;
    logic [XLEN-1:0]  r_result;

    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic [XLEN:0]    w_mul_sum;
    logic [XLEN-1:0]  w_div_diff;
    logic             w_div_ge;
    logic [XLEN-1:0]  w_step_hi;
    logic [XLEN-1:0]  w_step_lo;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]  w_quo;
    logic [XLEN-1:0]  w_rem;
    logic [XLEN-1:0]  w_final;
    logic             w_early;
    logic [XLEN-1:0]  w_early_res;

    // MULH and signed div/rem treat both operands as signed; MULHSU only a; MUL needs no sign handling.
    assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_a_neg    = w_a_signed & operand_a[XLEN-1];
    assign w_b_neg    = w_b_signed & operand_b[XLEN-1];
    assign w_mag_a    = w_a_neg ? neg_x(operand_a) : operand_a;
    assign w_mag_b    = w_b_neg ? neg_x(operand_b) : operand_b;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_div_diff = {r_hi[XLEN-2:0], r_lo[XLEN-1]} - r_mcand;
    assign w_div_ge   = {r_hi, r_lo[XLEN-1]} >= {1'b0, r_mcand};

    always_comb begin
        w_step_hi = {w_mul_sum[XLEN:1]};
        w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            if (w_div_ge) begin
                w_step_hi = w_div_diff;
                w_step_lo = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_step_hi = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                w_step_lo = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Divide-by-zero leaves an all-ones quotient that must not be sign-corrected.
    assign w_prod_fix = r_prod_neg ? neg_2x({r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quo      = (r_prod_neg && !r_bzero) ? neg_x(r_lo) : r_lo;
    assign w_rem      = r_rem_neg ? neg_x(r_hi) : r_hi;

    always_comb begin
        case (r_op)
            3'b000:                 w_final = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2]) begin
            if (operand_b == '0) begin
                w_early     = 1'b1;
                w_early_res = op[1] ? operand_a : '1;
            end else if (!op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b)) begin
                w_early     = 1'b1;
                w_early_res = op[1] ? '0 : operand_a;
            end
        end else if ((operand_a == '0) || (operand_b == '0)) begin
            w_early     = 1'b1;
            w_early_res = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_fin      <= 1'b0;
            r_op       <= 3'b000;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mcand    <= '0;
            r_prod_neg <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_bzero    <= 1'b0;
            r_stage    <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        r_op       <= op;
                        r_cnt      <= '0;
                        r_fin      <= 1'b0;
                        r_hi       <= '0;
                        r_prod_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg  <= w_a_neg;
                        r_bzero    <= ~|operand_b;
                        r_mcand    <= op[2] ? w_mag_b : w_mag_a;
                        r_lo       <= op[2] ? w_mag_a : w_mag_b;
                        if (w_early) begin
                            r_stage <= w_early_res;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else if (r_fin) begin
                        // Extra cycle after the last step applies the sign fix-up.
                        r_stage <= w_final;
                        r_state <= S_DONE;
                    end else begin
                        r_hi <= w_step_hi;
                        r_lo <= w_step_lo;
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (!kill) begin
                        r_result <= r_stage;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) && !kill;
    assign result = done ? r_stage : r_result;

endmodule
